pll_reset_ctrl: RTL and testbench
=================================

# pll_reset_ctrl

Sequencer for the iCE40 PLL and system reset release, clocked from the raw board reference clock. It pulses the PLL's `RESETB` and synchronises the asynchronous `LOCK` output. It holds the system reset request until lock has been stable for a programmable interval, and re-runs the sequence on loss of lock. It sits at top level between the board oscillator, the 12→36 MHz PLL wrapper and the reset synchroniser of the PLL output domain.

## Interface
Parameters:
- `RESET_PULSE_CYCLES`, 16: cycles `pll_resetb` is held low per PLL reset; min 1.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-lock-high cycles required before release; min 1.
- `TIMEOUT_CYCLES`, 65536: max cycles spent in WAIT_LOCK before retry (used only with the config macro); min 1.

Ports:
- `clk` in 1: reference clock (12 MHz, pre-PLL).
- `rst` in 1: synchronous, active-high reset.
- `pll_lock` in 1: PLL `LOCK`, asynchronous to `clk`.
- `pll_resetb` out 1: drives PLL `RESETB`; 0 = PLL in reset.
- `sys_rst_req` out 1: active-high reset request to the PLL-domain reset synchroniser.
- `ready` out 1: high in RUN only.
- `lock_lost` out 1: sticky; set when lock drops in RUN.
- `lock_lost_clr` in 1: clears `lock_lost`.
- `retry_count` out 4: saturating count of PLL reset sequences after the first.

## Operation
- `pll_lock` passes through a 2-flop synchroniser (reset 0) giving `lock_s`. All decisions use `lock_s` only.
- There is one shared down/up counter, sized `$clog2` of the largest parameter plus 1.
- States:
  - PLL_RST:
    - `pll_resetb`=0, `sys_rst_req`=1.
    - Counts RESET_PULSE_CYCLES, then → WAIT_LOCK with the counter cleared.
  - WAIT_LOCK:
    - `pll_resetb`=1, `sys_rst_req`=1.
    - `lock_s`=1 → STABLE with the counter cleared.
    - Timeout behaviour is given under Configuration.
  - STABLE:
    - `pll_resetb`=1, `sys_rst_req`=1.
    - Counter increments while `lock_s`=1.
    - `lock_s`=0 → WAIT_LOCK, counter cleared. The timeout restarts from 0.
    - Counter reaches LOCK_STABLE_CYCLES → RUN.
  - RUN:
    - `pll_resetb`=1, `sys_rst_req`=0, `ready`=1.
    - `lock_s`=0 → PLL_RST, counter cleared, `lock_lost` set.
    - Each entry to PLL_RST other than the one from `rst` increments `retry_count`, saturating at 15.
- `lock_lost`:
  - Set has priority over `lock_lost_clr` in the same cycle.
  - `lock_lost_clr` otherwise clears it the next cycle.
- Reset values:
  - State PLL_RST, counter 0.
  - `pll_resetb`=0, `sys_rst_req`=1, `ready`=0, `lock_lost`=0, `retry_count`=0, synchroniser 0.
- `rst` mid-sequence: everything returns to its reset value on the next edge. `retry_count` is not incremented.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- After the last cycle with `rst`=1:
  - `pll_resetb` stays 0 for exactly RESET_PULSE_CYCLES further cycles.
  - It then rises to 1.
- `pll_lock` rising to `lock_s`=1 takes 2 cycles.
- `lock_s`=1 to `sys_rst_req`=0 takes LOCK_STABLE_CYCLES+1 cycles: the STABLE count, then registered entry to RUN.
- Lock drop in RUN:
  - `pll_lock`=0 to `sys_rst_req`=1 takes 3 cycles: 2 for synchronisation, 1 registered.
  - `pll_resetb`=0 and `lock_lost`=1 change on the same edge as `sys_rst_req`.
- A single-cycle `lock_s` glitch in STABLE fully restarts the stable count.
- `sys_rst_req` never deasserts unless `lock_s` has been 1 for all of the last LOCK_STABLE_CYCLES cycles.

## Configuration
- `PLL_RST_CTRL_TIMEOUT_EN` defined:
  - WAIT_LOCK counts cycles.
  - At TIMEOUT_CYCLES without `lock_s` → PLL_RST, counter cleared, `retry_count` incremented.
- Not defined:
  - WAIT_LOCK waits indefinitely and its counter is held at 0.
  - The TIMEOUT_CYCLES parameter is ignored.
  - `retry_count` counts only RUN lock-loss events.

## Test plan
Bench parameters: RESET_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, TIMEOUT_CYCLES=32.
- Release `rst`, hold `pll_lock`=0 → `pll_resetb`=0 for exactly 4 cycles then 1; `sys_rst_req`=1 and `ready`=0 throughout.
- Then raise `pll_lock` and hold it → `sys_rst_req` falls and `ready` rises exactly 2+9 cycles after the `pll_lock` edge; `retry_count`=0.
- Drop `pll_lock` for 1 cycle in STABLE after 5 lock cycles → no release. Release occurs 2+9 cycles after `pll_lock` returns high.
- In RUN, drop `pll_lock` → 3 cycles later `sys_rst_req`=1, `pll_resetb`=0 for 4 cycles, `lock_lost`=1, `retry_count`=1. Assert `lock_lost_clr` → `lock_lost`=0 next cycle.
- With the macro defined and `pll_lock` held 0 → PLL reset pulses repeat every 4+32 cycles; `retry_count` saturates at 15 after 15 timeouts. Without the macro → one pulse only, `retry_count`=0.
- Assert `rst` for 1 cycle while in STABLE → all outputs return to reset values on the next edge; `retry_count` is unchanged at 0.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// PLL reset pulse and system reset release sequencer for the iCE40 PLL, clocked from the raw reference clock.
// Optional WAIT_LOCK timeout/retry is enabled by defining PLL_RST_CTRL_TIMEOUT_EN.
module pll_reset_ctrl #(
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int TIMEOUT_CYCLES     = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       lock_lost_clr,
    output logic       pll_resetb,
    output logic       sys_rst_req,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count
);

    localparam int MAX_RS     = (RESET_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                RESET_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_CYCLES = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_RST_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lock_meta;
    logic             lock_s;
    logic             retry_inc;
    logic             lost_set;

    // LOCK is asynchronous to clk; only lock_s is ever used for decisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PLL_RST;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        retry_inc  = 1'b0;
        lost_set   = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == PULSE_LAST) begin
                    next_state = WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                    cnt_next   = '0;
`ifdef PLL_RST_CTRL_TIMEOUT_EN
                end else if (cnt == TIMEOUT_LAST) begin
                    next_state = PLL_RST;
                    cnt_next   = '0;
                    retry_inc  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
`else
                end else begin
                    cnt_next = '0;
                end
`endif
            end
            STABLE: begin
                // Any drop of lock_s restarts the whole stable interval.
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    next_state = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    next_state = PLL_RST;
                    retry_inc  = 1'b1;
                    lost_set   = 1'b1;
                end
            end
            default: begin
                next_state = PLL_RST;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pll_resetb  <= 1'b0;
            sys_rst_req <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            pll_resetb  <= (next_state != PLL_RST);
            sys_rst_req <= (next_state != RUN);
            ready       <= (next_state == RUN);
            if (lost_set) begin
                lock_lost <= 1'b1;
            end else if (lock_lost_clr) begin
                lock_lost <= 1'b0;
            end
            if (retry_inc && (retry_count != 4'hF)) begin
                retry_count <= retry_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: the stimulus side pushes model predictions, a monitor pops and compares.
// Follows PLL_RST_CTRL_TIMEOUT_EN the same way as the design.
module tb_pll_reset_ctrl;

    localparam int R = 4;
    localparam int L = 8;
    localparam int T = 32;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       lock_lost_clr;
    logic       pll_resetb;
    logic       sys_rst_req;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;

    typedef struct packed {
        logic       pll_resetb;
        logic       sys_rst_req;
        logic       ready;
        logic       lock_lost;
        logic [3:0] retry;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: phases described by remaining pulse length, lock streak and idle wait length.
    logic hist[$];
    int   pulse_left;
    int   streak;
    int   wait_edges;
    bit   running;
    bit   m_lost;
    int   m_retry;

    pll_reset_ctrl #(
        .RESET_PULSE_CYCLES(R),
        .LOCK_STABLE_CYCLES(L),
        .TIMEOUT_CYCLES    (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .lock_lost_clr(lock_lost_clr),
        .pll_resetb   (pll_resetb),
        .sys_rst_req  (sys_rst_req),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .retry_count  (retry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic lk, input logic clr);
        logic ls;
        bit   lost_set;
        exp_t e;
        lost_set = 1'b0;
        if (r) begin
            hist       = '{1'b0, 1'b0};
            pulse_left = R;
            streak     = 0;
            wait_edges = 0;
            running    = 1'b0;
            m_lost     = 1'b0;
            m_retry    = 0;
        end else begin
            ls = hist[0];
            void'(hist.pop_front());
            hist.push_back(lk);
            if (pulse_left > 0) begin
                pulse_left--;
                if (pulse_left == 0) begin
                    streak     = 0;
                    wait_edges = 0;
                end
            end else if (running) begin
                if (!ls) begin
                    running    = 1'b0;
                    pulse_left = R;
                    lost_set   = 1'b1;
                    if (m_retry < 15) m_retry++;
                end
            end else if (ls) begin
                streak++;
                wait_edges = 0;
                if (streak == L + 1) begin
                    running = 1'b1;
                    streak  = 0;
                end
            end else if (streak > 0) begin
                streak     = 0;
                wait_edges = 0;
            end else begin
`ifdef PLL_RST_CTRL_TIMEOUT_EN
                wait_edges++;
                if (wait_edges == T) begin
                    pulse_left = R;
                    if (m_retry < 15) m_retry++;
                end
`endif
            end
            if (lost_set) m_lost = 1'b1;
            else if (clr) m_lost = 1'b0;
        end
        e.pll_resetb  = (pulse_left == 0);
        e.sys_rst_req = !running;
        e.ready       = running;
        e.lock_lost   = m_lost;
        e.retry       = 4'(m_retry);
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic r, input logic lk, input logic clr, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst           = r;
            pll_lock      = lk;
            lock_lost_clr = clr;
            model_step(r, lk, clr);
        end
    endtask

    // Drives lk until sys_rst_req reaches want, counting clock edges from the first drive.
    task automatic measure_latency(input logic lk, input logic want, input int expected, input string name);
        int edges;
        edges = 0;
        apply_stimulus(1'b0, lk, 1'b0, 1);
        while ((sys_rst_req != want) && (edges < 60)) begin
            apply_stimulus(1'b0, lk, 1'b0, 1);
            edges++;
        end
        check_output(name, edges, expected);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("pll_resetb",  pll_resetb,  e.pll_resetb);
            check_output("sys_rst_req", sys_rst_req, e.sys_rst_req);
            check_output("ready",       ready,       e.ready);
            check_output("lock_lost",   lock_lost,   e.lock_lost);
            check_output("retry_count", retry_count, e.retry);
        end
    end

    initial begin
        rst           = 1'b1;
        pll_lock      = 1'b0;
        lock_lost_clr = 1'b0;

        // Reset, pulse, first release and a lock drop in RUN.
        apply_stimulus(1'b1, 1'b0, 1'b0, 2);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10);
        measure_latency(1'b1, 1'b0, 11, "release_latency");
        check_output("ready_after_release", ready, 1);
        check_output("retry_after_release", retry_count, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 5);
        measure_latency(1'b0, 1'b1, 3, "drop_latency");
        check_output("pll_resetb_after_drop", pll_resetb, 0);
        check_output("lock_lost_after_drop", lock_lost, 1);
        check_output("retry_after_drop", retry_count, 1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1);
        check_output("lock_lost_cleared", lock_lost, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 8);

        // Single-cycle glitch after five synchronised lock cycles.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 1'b0, 7);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1);
        measure_latency(1'b1, 1'b0, 11, "glitch_release_latency");

        // One-cycle rst while in STABLE.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10);
        apply_stimulus(1'b0, 1'b1, 1'b0, 6);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1);
        check_output("pll_resetb_after_rst", pll_resetb, 0);
        check_output("retry_after_rst", retry_count, 0);

        // Lock never arrives: timeouts saturate the retry count, or a single pulse without the timeout.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 600);
`ifdef PLL_RST_CTRL_TIMEOUT_EN
        check_output("retry_saturated", retry_count, 15);
`else
        check_output("retry_no_timeout", retry_count, 0);
        check_output("pll_resetb_no_timeout", pll_resetb, 1);
`endif

        // Randomised lock segments with sporadic clears and resets.
        for (int s = 0; s < 250; s++) begin
            logic lk;
            int   len;
            lk  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 25);
            if ($urandom_range(0, 49) == 0) apply_stimulus(1'b1, lk, 1'b0, 1);
            for (int c = 0; c < len; c++) begin
                apply_stimulus(1'b0, lk, 1'($urandom_range(0, 7) == 0), 1);
            end
        end

        @(negedge clk);
        @(negedge clk);
        check_output("scoreboard_drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
